// File: rtl/rtc_display_selector.sv
// Selects time/date sources (manual or scanned) into registered display fields, with an edit-field blink mask.
// One-clock latency from inputs to all outputs; no backpressure, so invalid or frozen sources simply hold the outputs.
module rtc_display_selector #(
   parameter int N_SRC       = 2,
   parameter int W           = 8,
   parameter int SCAN_TICKS  = 4,
   parameter int BLINK_TICKS = 2,
   localparam int SELW       = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_SRC*3*W-1:0]   time_in,
   input  logic [N_SRC*3*W-1:0]   date_in,
   input  logic [N_SRC-1:0]       ampm_in,
   input  logic [N_SRC-1:0]       src_valid,
   input  logic [SELW-1:0]        sel_time,
   input  logic [SELW-1:0]        sel_date,
   input  logic                   scan_en,
   input  logic                   tick,
   input  logic                   freeze,
   input  logic [2:0]             edit_field,
   output logic [W-1:0]           hora,
   output logic [W-1:0]           min,
   output logic [W-1:0]           seg,
   output logic [W-1:0]           dia,
   output logic [W-1:0]           mes,
   output logic [W-1:0]           year,
   output logic                   ampm,
   output logic [5:0]             blank_mask,
   output logic                   upd,
   output logic [SELW-1:0]        cur_src_t,
   output logic [SELW-1:0]        cur_src_d
);

   localparam int SCW = $clog2(SCAN_TICKS + 1);
   localparam int BCW = $clog2(BLINK_TICKS + 1);

   typedef enum logic {VISIBLE, BLANK} blink_t;

   logic [3*W-1:0]  t_arr [N_SRC];
   logic [3*W-1:0]  d_arr [N_SRC];
   logic [SELW-1:0] scan_idx;
   logic [SCW-1:0]  scan_cnt;
   logic            scan_q;
   logic [SELW-1:0] eff_t, eff_d;
   logic            ld_t, ld_d, t_chg, d_chg;
   blink_t          state;
   logic [BCW-1:0]  blink_cnt;
   logic [2:0]      edit_q;
   logic            editing;
   logic [5:0]      field_bit;

   for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
      assign t_arr[k] = time_in[k*3*W +: 3*W];
      assign d_arr[k] = date_in[k*3*W +: 3*W];
   end

   // Out-of-range manual selects fall back to source 0.
   function automatic logic [SELW-1:0] clamp(input logic [SELW-1:0] s);
      return (int'(s) < N_SRC) ? s : '0;
   endfunction

   assign eff_t = scan_en ? scan_idx : clamp(sel_time);
   assign eff_d = scan_en ? scan_idx : clamp(sel_date);
   assign ld_t  = !freeze && src_valid[eff_t];
   assign ld_d  = !freeze && src_valid[eff_d];
   assign t_chg = ld_t && ({t_arr[eff_t], ampm_in[eff_t]} != {hora, min, seg, ampm});
   assign d_chg = ld_d && (d_arr[eff_d] != {dia, mes, year});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_q   <= 1'b0;
         scan_idx <= '0;
         scan_cnt <= '0;
      end else begin
         scan_q <= scan_en;
         if (scan_en && !scan_q) begin
            scan_idx <= '0;
            scan_cnt <= '0;
         end else if (scan_en && tick) begin
            if (scan_cnt == SCW'(SCAN_TICKS - 1)) begin
               scan_cnt <= '0;
               scan_idx <= (scan_idx == SELW'(N_SRC - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
               scan_cnt <= scan_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         {hora, min, seg, dia, mes, year} <= '0;
         ampm      <= 1'b0;
         upd       <= 1'b0;
         cur_src_t <= '0;
         cur_src_d <= '0;
      end else begin
         cur_src_t <= eff_t;
         cur_src_d <= eff_d;
         if (ld_t) begin
            {hora, min, seg} <= t_arr[eff_t];
            ampm             <= ampm_in[eff_t];
         end
         if (ld_d) begin
            {dia, mes, year} <= d_arr[eff_d];
         end
         upd <= t_chg || d_chg;
      end
   end

   assign editing = (edit_field != 3'd0) && (edit_field != 3'd7);

   always_comb begin
      field_bit = '0;
      case (edit_field)
         3'd1:    field_bit = 6'b100000;
         3'd2:    field_bit = 6'b010000;
         3'd3:    field_bit = 6'b001000;
         3'd4:    field_bit = 6'b000100;
         3'd5:    field_bit = 6'b000010;
         3'd6:    field_bit = 6'b000001;
         default: field_bit = 6'b000000;
      endcase
   end

   // The mask is updated alongside the state so it always reflects the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= VISIBLE;
         blink_cnt  <= '0;
         edit_q     <= 3'd0;
         blank_mask <= '0;
      end else begin
         edit_q <= edit_field;
         if ((edit_field != edit_q) || !editing) begin
            state      <= VISIBLE;
            blink_cnt  <= '0;
            blank_mask <= '0;
         end else if (tick) begin
            if (blink_cnt == BCW'(BLINK_TICKS - 1)) begin
               blink_cnt  <= '0;
               state      <= (state == VISIBLE) ? BLANK : VISIBLE;
               blank_mask <= (state == VISIBLE) ? field_bit : 6'b000000;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rtc_display_selector.sv
// Directed bench for rtc_display_selector: stimulus queues expected snapshots, a monitor compares them at negedge.
module tb_rtc_display_selector;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] t0, t1, t2, d0, d1, d2;
   logic [71:0] time_in, date_in;
   logic [2:0]  ampm_in, src_valid;
   logic [1:0]  sel_time, sel_date;
   logic        scan_en, tick, freeze;
   logic [2:0]  edit_field;
   logic [7:0]  hora, min, seg, dia, mes, year;
   logic        ampm, upd;
   logic [5:0]  blank_mask;
   logic [1:0]  cur_src_t, cur_src_d;
   logic [59:0] obs;

   assign time_in = {t2, t1, t0};
   assign date_in = {d2, d1, d0};
   assign obs = {hora, min, seg, dia, mes, year, ampm, blank_mask, upd, cur_src_t, cur_src_d};

   always #5 clk = ~clk;

   rtc_display_selector #(.N_SRC(3), .W(8), .SCAN_TICKS(2), .BLINK_TICKS(2)) dut (
      .clk(clk), .reset(reset), .time_in(time_in), .date_in(date_in), .ampm_in(ampm_in),
      .src_valid(src_valid), .sel_time(sel_time), .sel_date(sel_date), .scan_en(scan_en),
      .tick(tick), .freeze(freeze), .edit_field(edit_field), .hora(hora), .min(min),
      .seg(seg), .dia(dia), .mes(mes), .year(year), .ampm(ampm), .blank_mask(blank_mask),
      .upd(upd), .cur_src_t(cur_src_t), .cur_src_d(cur_src_d)
   );

   localparam logic [59:0] C_T   = {24'hFFFFFF, 36'h0};
   localparam logic [59:0] C_D   = {24'h0, 24'hFFFFFF, 12'h0};
   localparam logic [59:0] C_M   = {49'h0, 6'h3F, 5'h0};
   localparam logic [59:0] C_U   = {55'h0, 1'b1, 4'h0};
   localparam logic [59:0] C_CT  = {56'h0, 2'b11, 2'b00};
   localparam logic [59:0] C_ALL = {60{1'b1}};

   typedef struct {
      int          cyc;
      string       name;
      logic [59:0] exp;
      logic [59:0] care;
   } exp_t;

   exp_t sbq[$];
   int   mcyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [59:0] ob(logic [23:0] t, logic [23:0] d, logic ap, logic [5:0] m,
                                      logic u, logic [1:0] ct, logic [1:0] cd);
      return {t, d, ap, m, u, ct, cd};
   endfunction

   task automatic chk(string nm, logic [59:0] e, logic [59:0] c);
      exp_t x;
      x.cyc = mcyc + 1; x.name = nm; x.exp = e; x.care = c;
      sbq.push_back(x);
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      tick_clk();
      tick = 1'b0;
      repeat (3) tick_clk();
   endtask

   // Monitor: pops every expectation due at this negedge and compares the cared-about bits.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         mcyc++;
         while (sbq.size() > 0 && sbq[0].cyc <= mcyc) begin
            e = sbq.pop_front();
            n_cmp++;
            if ((obs & e.care) !== (e.exp & e.care)) begin
               n_bad++;
               $display("FAIL %s: got %h want %h (care %h)", e.name, obs & e.care, e.exp & e.care, e.care);
            end
         end
      end
   end

   initial begin
      logic [23:0] tv [3];
      logic [23:0] dv [3];
      logic [1:0]  seq [7];
      logic [5:0]  bl [7];
      seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
      bl  = '{6'h00, 6'h00, 6'h10, 6'h10, 6'h00, 6'h00, 6'h10};
      tv  = '{24'h123456, 24'h010203, 24'h235959};
      dv  = '{24'h150624, 24'h311299, 24'h280225};

      reset = 1'b0;
      t0 = tv[0]; t1 = tv[1]; t2 = tv[2];
      d0 = dv[0]; d1 = dv[1]; d2 = dv[2];
      ampm_in = 3'b010; src_valid = 3'b111;
      sel_time = 2'd0; sel_date = 2'd0;
      scan_en = 1'b0; tick = 1'b0; freeze = 1'b0; edit_field = 3'd0;

      repeat (2) tick_clk();
      chk("reset_state", '0, C_ALL);
      reset = 1'b1;
      tick_clk();
      chk("first_load", ob(24'h123456, 24'h150624, 0, 0, 1, 0, 0), C_ALL);
      tick_clk();
      chk("same_load_no_upd", ob(24'h123456, 24'h150624, 0, 0, 0, 0, 0), C_ALL);

      sel_time = 2'd1;
      tick_clk();
      chk("sel_time_1", ob(24'h010203, 24'h150624, 1, 0, 1, 1, 0), C_ALL);
      tick_clk();
      chk("upd_one_cycle", '0, C_U);
      sel_time = 2'd3;
      tick_clk();
      chk("sel_out_of_range", ob(24'h123456, 24'h150624, 0, 0, 1, 0, 0), C_ALL);
      sel_date = 2'd2;
      tick_clk();
      chk("sel_date_2", ob(24'h123456, 24'h280225, 0, 0, 1, 0, 2), C_ALL);

      sel_time = 2'd1; src_valid = 3'b101; t1 = 24'h111111;
      tick_clk();
      chk("invalid_hold_a", ob(24'h123456, 24'h280225, 0, 0, 0, 1, 2), C_ALL);
      t1 = 24'h222222;
      tick_clk();
      chk("invalid_hold_b", ob(24'h123456, 24'h280225, 0, 0, 0, 1, 2), C_ALL);
      src_valid = 3'b111;
      tick_clk();
      chk("valid_again", ob(24'h222222, 24'h280225, 1, 0, 1, 1, 2), C_ALL);

      freeze = 1'b1; sel_time = 2'd0;
      tick_clk();
      chk("freeze_hold", ob(24'h222222, 24'h280225, 1, 0, 0, 0, 2), C_ALL);
      freeze = 1'b0; sel_date = 2'd0; t1 = tv[1];
      tick_clk();
      chk("unfreeze_load", ob(24'h123456, 24'h150624, 0, 0, 1, 0, 0), C_ALL);

      scan_en = 1'b1;
      tick_clk();
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("scan_seq_%0d", k), ob(tv[seq[k]], dv[seq[k]], 0, 0, 0, seq[k], 0), C_T | C_D | C_CT);
         if (k < 6) do_tick();
      end

      freeze = 1'b1;
      do_tick(); do_tick();
      chk("freeze_scan_1", ob(24'h123456, 24'h150624, 0, 0, 0, 1, 0), C_T | C_D | C_U | C_CT);
      do_tick(); do_tick();
      chk("freeze_scan_2", ob(24'h123456, 24'h150624, 0, 0, 0, 2, 0), C_T | C_D | C_U | C_CT);
      freeze = 1'b0;
      tick_clk();
      chk("unfreeze_scan", ob(24'h235959, 24'h280225, 0, 0, 1, 2, 0), C_T | C_D | C_U | C_CT);

      scan_en = 1'b0;
      tick_clk();
      scan_en = 1'b1; tick = 1'b1;
      tick_clk();
      tick = 1'b0;
      repeat (2) tick_clk();
      chk("scan_restart_clear", '0, C_CT);
      do_tick();
      chk("scan_restart_tick1", '0, C_CT);
      do_tick();
      chk("scan_restart_tick2", ob(0, 0, 0, 0, 0, 1, 0), C_CT);

      edit_field = 3'd2;
      tick_clk();
      for (int j = 0; j < 7; j++) begin
         chk($sformatf("blink_%0d", j), ob(0, 0, 0, bl[j], 0, 0, 0), C_M);
         if (j < 6) do_tick();
      end
      do_tick();
      chk("blink_blank_cnt1", ob(0, 0, 0, 6'h10, 0, 0, 0), C_M);
      edit_field = 3'd5;
      tick_clk();
      chk("edit_change_visible", '0, C_M);
      do_tick();
      chk("blink_restart_1", '0, C_M);
      do_tick();
      chk("blink_mes_blank", ob(0, 0, 0, 6'h02, 0, 0, 0), C_M);
      edit_field = 3'd7;
      tick_clk();
      chk("edit7_visible", '0, C_M);
      do_tick(); do_tick();
      chk("edit7_held", '0, C_M);

      edit_field = 3'd2;
      tick_clk();
      do_tick();
      reset = 1'b0;
      chk("async_reset", '0, C_ALL);
      tick_clk();
      chk("reset_held", '0, C_ALL);
      scan_en = 1'b0; sel_time = 2'd0; sel_date = 2'd0; edit_field = 3'd0;
      reset = 1'b1;
      tick_clk();
      chk("post_reset_load", ob(24'h123456, 24'h150624, 0, 0, 1, 0, 0), C_ALL);

      for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clk);
      if (sbq.size() > 0) begin
         $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
         n_cmp += sbq.size();
         n_bad += sbq.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rtc_display_selector.md
RTC_DISPLAY_SELECTOR -- requirements
Module: rtc_display_selector

Parameters
REQ-001 The block SHALL have parameter N_SRC, default 2, the number of time/date sources (2..8).
REQ-002 The block SHALL have parameter W, default 8, the width of each BCD field.
REQ-003 The block SHALL have parameter SCAN_TICKS, default 4, the number of ticks per source in scan mode.
REQ-004 The block SHALL have parameter BLINK_TICKS, default 2, the number of ticks per blink phase.
REQ-005 The block SHALL derive SELW = max(1, clog2(N_SRC)).

Interface
REQ-006 The block SHALL have these ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- time_in  in  N_SRC*3*W  source k at [k*3W +: 3W], ordered {hora,min,seg}, hora most significant.
- date_in  in  N_SRC*3*W  source k packed as {dia,mes,year}.
- ampm_in  in  N_SRC  AM/PM flag per source.
- src_valid  in  N_SRC  per-source flag; 1 = data coherent and loadable.
- sel_time  in  SELW  manual time-source select.
- sel_date  in  SELW  manual date-source select.
- scan_en  in  1  automatic source scanning enable.
- tick  in  1  one-cycle timebase pulse.
- freeze  in  1  hold all data outputs.
- edit_field  in  3  field under edit: 0 = none, 1 = hora, 2 = min, 3 = seg, 4 = dia, 5 = mes, 6 = year, 7 = none.
- hora, min, seg, dia, mes, year  out  W each  registered fields.
- ampm  out  1  registered AM/PM flag.
- blank_mask  out  6  per-field blank flags, bit5 = hora down to bit0 = year.
- upd  out  1  one-cycle pulse after any data output changes.
- cur_src_t, cur_src_d  out  SELW  effective sources for time and date.

Function
REQ-007 Manual mode (scan_en = 0): the effective time source SHALL be sel_time and the effective date source SHALL be sel_date; a select value >= N_SRC SHALL map to source 0.
REQ-008 Scan mode (scan_en = 1): both effective sources SHALL equal scan_idx.
REQ-009 scan_idx SHALL advance by 1 after every SCAN_TICKS ticks and SHALL wrap from N_SRC-1 to 0.
REQ-010 On the cycle scan_en goes 0 to 1, scan_idx and the scan tick counter SHALL clear to 0; this load SHALL take priority over a coincident tick.
REQ-011 cur_src_t and cur_src_d SHALL be registered copies of the effective sources, with one-cycle latency.
REQ-012 Time load: when freeze = 0 and src_valid of the effective time source = 1, hora, min, seg and ampm SHALL load that source's values at the next clock edge. Otherwise they SHALL hold.
REQ-013 Date load: the same rule as REQ-012, applied independently to dia, mes and year using the effective date source.
REQ-014 Input-to-output latency SHALL be exactly one clock. There SHALL be no combinational path from any input to any output.
REQ-015 freeze SHALL NOT stop scan_idx, the tick counters or the blink logic.
REQ-016 upd SHALL be 1 for exactly one cycle, on the cycle after a load changes any of hora..year or ampm. A load of identical values SHALL NOT assert upd.
REQ-017 Blink FSM states: VISIBLE and BLANK. While edit_field is in 1..6, the state SHALL toggle after every BLINK_TICKS ticks.
REQ-018 A change of edit_field SHALL force the FSM to VISIBLE and clear the blink counter; this SHALL take priority over a coincident tick.
REQ-019 When edit_field is 0 or 7, the FSM SHALL be held in VISIBLE.
REQ-020 blank_mask SHALL have only the bit of the edited field set while in BLANK, and SHALL be 0 otherwise; it SHALL be registered.
REQ-021 Data outputs SHALL NOT be altered by blinking. Blanking SHALL be applied downstream using blank_mask.
REQ-022 A tick while scan_en = 0 SHALL NOT change scan_idx.

Reset
REQ-023 While reset = 0, all outputs SHALL be 0, the FSM SHALL be in VISIBLE, and scan_idx and all counters SHALL be 0; this SHALL take effect immediately, without a clock.
REQ-024 Assertion of reset in the middle of a scan or blink sequence SHALL abort it. After release, the first load SHALL occur on the first clock edge at which the REQ-012/REQ-013 load conditions are met.

Verification (N_SRC=3, W=8, SCAN_TICKS=2, BLINK_TICKS=2)
REQ-025 With src0 time = 0x123456, src1 time = 0x010203, all src_valid = 1, sel_time 0 -> 1 -> hora/min/seg = 01/02/03 one clock later, with upd pulsed for 1 cycle.
REQ-026 With sel_time = 3 (out of range) -> outputs show src0 time 12/34/56 and cur_src_t = 0.
REQ-027 With src_valid[1] = 0 while sel_time = 1 and src1 data changing -> outputs hold their previous values and upd = 0. Then src_valid[1] = 1 -> new values appear one clock later.
REQ-028 scan_en = 1 with a tick every 4 clocks -> cur_src_t sequence 0,0,1,1,2,2,0 per tick. With freeze = 1 -> the index still advances and the data outputs hold.
REQ-029 edit_field = 2 with ticks -> blank_mask 000000 for 2 ticks, 010000 for 2 ticks, repeating. Changing edit_field to 5 during BLANK -> blank_mask = 000000 on the next clock and the blink counter restarts.
REQ-030 Assert reset = 0 asynchronously mid-scan with nonzero outputs -> all outputs = 0 before the next clock edge. Release with src_valid = 1 -> src0 data appears after the first clock edge.
